pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the 32-bit processor. It holds the architectural PC and drives `pc_plus4` into input 0 of the downstream next-PC 2:1 mux. It consumes that mux's output as `next_pc`, issues one-outstanding instruction-memory requests, and presents each fetched instruction to decode through a valid/ready handshake.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `next_pc`, input, 32: next-PC mux output; sampled only at PC-update events.
- `pc_plus4`, output, 32: `pc + 4`, combinational from `pc`; drives mux `in0`.
- `pc`, output, 32: current PC register.
- `flush`, input, 1: redirect request; PC reloads from `next_pc`.
- `imem_req`, output, 1: fetch request valid.
- `imem_addr`, output, 32: fetch address, equal to `pc`.
- `imem_ready`, input, 1: memory accepts the request this cycle.
- `imem_rvalid`, input, 1: read data valid.
- `imem_rdata`, input, 32: instruction word.
- `instr`, output, 32: registered instruction to decode.
- `instr_valid`, output, 1: `instr` is valid.
- `instr_ready`, input, 1: decode accepts `instr`.
- `instr_count`, output, 32: count of instructions accepted by decode; wraps at 2^32.
- `misalign`, output, 1: sticky flag set when a loaded `next_pc[1:0] != 2'b00`.

## Operation
FSM states:
- **REQ**
  - `imem_req = 1`.
  - `imem_ready = 1`: go to WAIT.
  - `flush = 1 && imem_ready = 0`: `pc <= next_pc`, stay in REQ.
  - `flush = 1 && imem_ready = 1`: `pc <= next_pc`, set `discard`, go to WAIT.
- **WAIT**
  - `imem_req = 0`.
  - `flush`: `pc <= next_pc`, set `discard`.
  - `imem_rvalid = 1 && !discard`: `instr <= imem_rdata`, go to HOLD.
  - `imem_rvalid = 1 && discard`: drop the data, clear `discard`, go to REQ.
  - `imem_rvalid` and `flush` in the same cycle: the data is dropped, `pc <= next_pc`, go to REQ.
- **HOLD**
  - `instr_valid = 1`.
  - `instr_ready = 1 && !flush`: `pc <= next_pc`, `instr_count++`, go to REQ.
  - `flush = 1`: `pc <= next_pc`, no count, go to REQ. `flush` wins over `instr_ready`.
  - Otherwise hold; `instr` stays stable.

Other rules:
- `pc` updates only at the events above, so the mux output is consumed exactly once per instruction or redirect.
- `misalign` is set on any `pc` load whose `next_pc[1:0] != 0`. It is cleared only by reset. Fetch proceeds anyway, with the address unmodified.
- `pc_plus4` is modulo 2^32: `32'hFFFF_FFFC + 4 = 0`.
- `imem_rvalid` is ignored in REQ and HOLD.
- `imem_ready` is ignored outside REQ.

## Timing
- Reset values while `rst_n = 0`:
  - state = REQ, but `imem_req` is forced to 0.
  - `pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`.
  - `instr = 0`, `instr_valid = 0`, `instr_count = 0`, `misalign = 0`, `discard = 0`.
- `imem_req = 1` in the first cycle after `rst_n` rises.
- Request accepted in cycle T → earliest `imem_rvalid` in T+1 → `instr_valid` in T+2.
- Accept in HOLD in cycle A → next `imem_req` in A+1. Peak throughput is one instruction per 3 cycles.
- An asynchronous reset mid-operation aborts any outstanding request. A late `imem_rvalid` then arrives in REQ and is ignored.
- `instr_valid` is deasserted in the cycle after a flush or accept in HOLD.

## Test plan
- **Reset/first fetch:** `RESET_PC = 32'h100`, `imem_ready = 1`, rvalid one cycle later with `32'hDEAD_BEEF`, `next_pc` tied to `pc_plus4` → `imem_addr = 32'h100`; `instr = 32'hDEADBEEF` valid at T+2; after accept `pc = 32'h104`, `instr_count = 1`.
- **Decode backpressure:** hold `instr_ready = 0` for 5 cycles → `instr` and `instr_valid` stable, `pc` unchanged, no new `imem_req`; accept → `pc` advances once.
- **Flush during WAIT:** flush with `next_pc = 32'h200`, then rvalid with `32'h1111_1111` → data dropped, `instr_valid` stays 0, next `imem_addr = 32'h200`.
- **Flush plus ready in HOLD:** flush and `instr_ready` in the same cycle with `next_pc = 32'h300` → `instr_count` unchanged, `pc = 32'h300`.
- **Wrap and misalign:**
  - `pc = 32'hFFFF_FFFC` → `pc_plus4 = 0`; load it, then fetch at 0.
  - Load `next_pc = 32'h102` → `misalign = 1` and stays 1 until reset.
- **Async reset mid-WAIT:** pulse `rst_n` low mid-WAIT, then rvalid → all outputs return to reset values immediately; stale rvalid ignored; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: one outstanding imem request,
// registered instruction handed to decode through a valid/ready handshake.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_count,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic discard;
  logic discard_n;
  logic pc_load;
  logic capture;
  logic count_en;

  // State register and datapath; pc only moves on pc_load so next_pc is consumed once per event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      discard     <= 1'b0;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_count <= 32'h0;
      misalign    <= 1'b0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
      if (pc_load) begin
        pc <= next_pc;
        if (next_pc[1:0] != 2'b00) begin
          misalign <= 1'b1;
        end
      end
      if (capture) begin
        instr <= imem_rdata;
      end
      if (count_en) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  // discard marks the in-flight response as belonging to a redirected-away PC.
  always_comb begin
    state_n   = state;
    discard_n = discard;
    pc_load   = 1'b0;
    capture   = 1'b0;
    count_en  = 1'b0;
    case (state)
      S_REQ: begin
        if (flush) begin
          pc_load = 1'b1;
          if (imem_ready) begin
            discard_n = 1'b1;
            state_n   = S_WAIT;
          end
        end else if (imem_ready) begin
          discard_n = 1'b0;
          state_n   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_load = 1'b1;
          if (imem_rvalid) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            capture = 1'b1;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_load = 1'b1;
          state_n = S_REQ;
        end else if (instr_ready) begin
          pc_load  = 1'b1;
          count_en = 1'b1;
          state_n  = S_REQ;
        end
      end
      default: begin
        state_n   = S_REQ;
        discard_n = 1'b0;
      end
    endcase
  end

  // The request is gated by rst_n so nothing is issued while reset is held.
  assign imem_req    = rst_n && (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign pc_plus4    = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit; fetched words go through a scoreboard queue.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_count;
  logic        misalign;

  logic        tie_plus4;
  logic [31:0] forced_pc;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  int          checks;
  int          errors;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_plus4(pc_plus4), .pc(pc),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_count(instr_count),
    .misalign(misalign)
  );

  assign next_pc = tie_plus4 ? pc_plus4 : forced_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a request from REQ, answer it one cycle later, land in HOLD.
  task automatic do_fetch(input logic [31:0] data);
    imem_ready = 1'b1;
    cycle();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back(data);
    cycle();
    imem_rvalid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    tie_plus4 = 1'b0;
    forced_pc = target;
    flush     = 1'b1;
    cycle();
    flush     = 1'b0;
    tie_plus4 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    checks++;
    if (pc !== RST_PC || pc_plus4 !== RST_PC + 32'd4) begin
      errors++; $display("[TB] FAIL reset_pc got %h/%h exp %h/%h", pc, pc_plus4, RST_PC, RST_PC + 32'd4);
    end
    checks++;
    if ({imem_req, instr_valid, misalign} !== 3'b000 || instr !== 32'h0 || instr_count !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_outputs got req%b v%b m%b i%h c%h exp all zero",
                         imem_req, instr_valid, misalign, instr, instr_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("[TB] FAIL first_req got %b/%h exp 1/%h", imem_req, imem_addr, RST_PC);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    imem_ready = 1'b1;
    cycle();
    imem_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wait_state got req%b v%b exp 0 0", imem_req, instr_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    cycle();
    imem_rvalid = 1'b0;
    exp_word = exp_q.pop_front();
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++; $display("[TB] FAIL first_instr got v%b %h exp v1 %h", instr_valid, instr, exp_word);
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    checks++;
    if (pc !== 32'h104 || instr_count !== 32'd1 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL first_accept got pc %h cnt %0d v%b req%b exp 104 1 0 1",
                         pc, instr_count, instr_valid, imem_req);
    end
  endtask

  task automatic test_backpressure();
    do_fetch(32'hA5A5_0001);
    exp_word = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_word || pc !== 32'h104 || imem_req !== 1'b0) begin
        errors++; $display("[TB] FAIL stall%0d got v%b %h pc %h req%b exp v1 %h pc 104 req0",
                           i, instr_valid, instr, pc, imem_req, exp_word);
      end
      cycle();
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    checks++;
    if (pc !== 32'h108 || instr_count !== 32'd2) begin
      errors++; $display("[TB] FAIL stall_accept got pc %h cnt %0d exp 108 2", pc, instr_count);
    end
  endtask

  task automatic test_flush_wait();
    imem_ready = 1'b1;
    cycle();
    imem_ready = 1'b0;
    redirect(32'h200);
    checks++;
    if (pc !== 32'h200 || imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_wait_pc got %h req%b exp 200 req0", pc, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    cycle();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("[TB] FAIL flush_wait_drop got v%b req%b addr %h exp v0 req1 200",
                         instr_valid, imem_req, imem_addr);
    end
    cycle();
    checks++;
    if (instr_valid !== 1'b0 || instr_count !== 32'd2) begin
      errors++; $display("[TB] FAIL flush_wait_quiet got v%b cnt %0d exp v0 2", instr_valid, instr_count);
    end
  endtask

  task automatic test_flush_hold();
    do_fetch(32'h2222_2222);
    exp_word = exp_q.pop_front();
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word) begin
      errors++; $display("[TB] FAIL hold_instr got v%b %h exp v1 %h", instr_valid, instr, exp_word);
    end
    instr_ready = 1'b1;
    redirect(32'h300);
    instr_ready = 1'b0;
    checks++;
    if (pc !== 32'h300 || instr_count !== 32'd2 || instr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_hold got pc %h cnt %0d v%b exp 300 2 0", pc, instr_count, instr_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    exp_pc  = 32'h300;
    exp_cnt = 32'd2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        errors++; $display("[TB] FAIL b2b_req%0d got req%b %h exp req1 %h", i, imem_req, imem_addr, exp_pc);
      end
      do_fetch($urandom);
      exp_word = exp_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_word) begin
        errors++; $display("[TB] FAIL b2b_instr%0d got v%b %h exp v1 %h", i, instr_valid, instr, exp_word);
      end
      instr_ready = 1'b1;
      cycle();
      instr_ready = 1'b0;
      exp_pc  = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
      checks++;
      if (pc !== exp_pc || instr_count !== exp_cnt) begin
        errors++; $display("[TB] FAIL b2b_adv%0d got pc %h cnt %0d exp %h %0d", i, pc, instr_count, exp_pc, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap_misalign();
    redirect(32'hFFFF_FFFC);
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || misalign !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_load got pc %h p4 %h m%b req%b exp fffffffc 0 m0 req1",
                         pc, pc_plus4, misalign, imem_req);
    end
    do_fetch(32'h3333_3333);
    exp_word = exp_q.pop_front();
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || misalign !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_fetch got pc %h addr %h req%b m%b exp 0 0 req1 m0",
                         pc, imem_addr, imem_req, misalign);
    end
    redirect(32'h102);
    checks++;
    if (misalign !== 1'b1 || imem_addr !== 32'h102) begin
      errors++; $display("[TB] FAIL misalign_set got m%b addr %h exp m1 102", misalign, imem_addr);
    end
    redirect(32'h400);
    do_fetch(32'h4444_4444);
    exp_word = exp_q.pop_front();
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    checks++;
    if (misalign !== 1'b1 || pc !== 32'h404) begin
      errors++; $display("[TB] FAIL misalign_sticky got m%b pc %h exp m1 404", misalign, pc);
    end
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b1;
    cycle();
    imem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== RST_PC || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_count !== 32'h0
        || misalign !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset got pc %h req%b v%b cnt %0d m%b i%h exp %h 0 0 0 0 0",
                         pc, imem_req, instr_valid, instr_count, misalign, instr, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    cycle();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("[TB] FAIL stale_rvalid got v%b req%b addr %h exp v0 req1 %h",
                         instr_valid, imem_req, imem_addr, RST_PC);
    end
    do_fetch(32'h5555_5555);
    exp_word = exp_q.pop_front();
    checks++;
    if (instr !== exp_word) begin
      errors++; $display("[TB] FAIL restart_instr got %h exp %h", instr, exp_word);
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    checks++;
    if (pc !== RST_PC + 32'd4 || instr_count !== 32'd1) begin
      errors++; $display("[TB] FAIL restart_accept got pc %h cnt %0d exp %h 1", pc, instr_count, RST_PC + 32'd4);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    tie_plus4   = 1'b1;
    forced_pc   = 32'h0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_flush_wait();
    test_flush_hold();
    test_back_to_back();
    test_wrap_misalign();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
